// File: rtl/decoder_pkg.sv
// Shared widths and the one-hot decode function for the 3-to-8 decoder.
package decoder_pkg;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;

  // Active-high one-hot decode. A select with unknown bits falls through to
  // the default arm in simulation and yields no active line.
  function automatic logic [OUT_W-1:0] onehot_dec(input logic [SEL_W-1:0] sel);
    logic [OUT_W-1:0] oh;
    case (sel)
      3'd0:    oh = 8'b0000_0001;
      3'd1:    oh = 8'b0000_0010;
      3'd2:    oh = 8'b0000_0100;
      3'd3:    oh = 8'b0000_1000;
      3'd4:    oh = 8'b0001_0000;
      3'd5:    oh = 8'b0010_0000;
      3'd6:    oh = 8'b0100_0000;
      3'd7:    oh = 8'b1000_0000;
      default: oh = 8'b0000_0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/decoder_3x8_core.sv
// Purely combinational enable-gated decode with output polarity selection.
module decoder_3x8_core
  import decoder_pkg::*;
#(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic             enable_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [OUT_W-1:0] line_o,
  output logic             hit_o
);

  logic [OUT_W-1:0] oh;

  // Gate the decode with enable, flag whether a line is active, then apply polarity.
  always_comb begin
    oh     = enable_i ? onehot_dec(sel_i) : '0;
    hit_o  = |oh;
    line_o = OUT_ACTIVE_LOW ? ~oh : oh;
  end

endmodule

// File: rtl/decoder_3x8.sv
// 3-to-8 decoder top: optional output register with synchronous active-low
// reset and a valid flag marking a decode made while enabled.
module decoder_3x8
  import decoder_pkg::*;
#(
  parameter bit OUT_ACTIVE_LOW = 1'b0,
  parameter bit REG_OUT        = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [OUT_W-1:0] line,
  input  logic             enable,
  input  logic             a2,
  input  logic             a1,
  input  logic             a0,
  output logic             line_valid
);

  localparam logic [OUT_W-1:0] LINE_IDLE = OUT_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [SEL_W-1:0] sel;
  logic [OUT_W-1:0] line_d;
  logic             valid_d;

  assign sel = {a2, a1, a0};

  decoder_3x8_core #(
    .OUT_ACTIVE_LOW (OUT_ACTIVE_LOW)
  ) u_core (
    .enable_i (enable),
    .sel_i    (sel),
    .line_o   (line_d),
    .hit_o    (valid_d)
  );

  generate
    if (REG_OUT) begin : g_reg
      logic [OUT_W-1:0] line_q;
      logic             valid_q;

      // Register the decode; reset wins over enable and select.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          line_q  <= LINE_IDLE;
          valid_q <= 1'b0;
        end else begin
          line_q  <= line_d;
          valid_q <= valid_d;
        end
      end

      assign line       = line_q;
      assign line_valid = valid_q;
    end else begin : g_comb
      // Zero-latency path: clock and reset play no part here.
      assign line       = line_d;
      assign line_valid = valid_d;
    end
  endgenerate

endmodule

// File: tb/tb_decoder_3x8.sv
// Directed-vector bench for decoder_3x8: registered active-high, registered
// active-low and combinational instances share one set of inputs.
module tb_decoder_3x8;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       a2, a1, a0;
  logic [7:0] line_hi, line_lo, line_cb;
  logic       vld_hi, vld_lo, vld_cb;

  int total = 0;
  int bad   = 0;

  decoder_3x8 #(.OUT_ACTIVE_LOW(1'b0), .REG_OUT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .line(line_hi), .enable(enable),
    .a2(a2), .a1(a1), .a0(a0), .line_valid(vld_hi));

  decoder_3x8 #(.OUT_ACTIVE_LOW(1'b1), .REG_OUT(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n), .line(line_lo), .enable(enable),
    .a2(a2), .a1(a1), .a0(a0), .line_valid(vld_lo));

  decoder_3x8 #(.OUT_ACTIVE_LOW(1'b0), .REG_OUT(1'b0)) dut_cb (
    .clk(clk), .rst_n(rst_n), .line(line_cb), .enable(enable),
    .a2(a2), .a1(a1), .a0(a0), .line_valid(vld_cb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic en, input logic [2:0] s);
    enable = en;
    {a2, a1, a0} = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1'b1, 3'd5);
    tick();
    tick();
    total++;
    if (line_hi !== 8'h00 || vld_hi !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: line=%h valid=%b want line=00 valid=0", line_hi, vld_hi);
    end
    total++;
    if (line_lo !== 8'hFF || vld_lo !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold_al: line=%h valid=%b want line=ff valid=0", line_lo, vld_lo);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (line_hi !== 8'b0010_0000 || vld_hi !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: line=%h valid=%b want line=20 valid=1", line_hi, vld_hi);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_tab [8];
    exp_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 3'(i));
      #1;
      total++;
      if (line_cb !== exp_tab[i] || vld_cb !== 1'b1) begin
        bad++;
        $display("FAIL sweep_comb sel=%0d: line=%h valid=%b want line=%h valid=1",
                 i, line_cb, vld_cb, exp_tab[i]);
      end
      tick();
      total++;
      if (line_hi !== exp_tab[i] || vld_hi !== 1'b1 || $countones(line_hi) != 1) begin
        bad++;
        $display("FAIL sweep sel=%0d: line=%h valid=%b want line=%h valid=1",
                 i, line_hi, vld_hi, exp_tab[i]);
      end
    end
  endtask

  task automatic test_enable_gating();
    for (int s = 1; s <= 3; s++) begin
      set_in(1'b0, 3'(s));
      tick();
      total++;
      if (line_hi !== 8'h00 || vld_hi !== 1'b0) begin
        bad++;
        $display("FAIL gate_off sel=%0d: line=%h valid=%b want line=00 valid=0", s, line_hi, vld_hi);
      end
    end
    #1;
    total++;
    if (line_cb !== 8'h00 || vld_cb !== 1'b0) begin
      bad++;
      $display("FAIL gate_off_comb: line=%h valid=%b want line=00 valid=0", line_cb, vld_cb);
    end
    set_in(1'b1, 3'd3);
    tick();
    total++;
    if (line_hi !== 8'h08 || vld_hi !== 1'b1) begin
      bad++;
      $display("FAIL gate_on: line=%h valid=%b want line=08 valid=1", line_hi, vld_hi);
    end
  endtask

  task automatic test_back_to_back();
    set_in(1'b1, 3'd1);
    tick();
    total++;
    if (line_hi !== 8'h02 || vld_hi !== 1'b1) begin
      bad++;
      $display("FAIL toggle_a: line=%h valid=%b want line=02 valid=1", line_hi, vld_hi);
    end
    set_in(1'b0, 3'd2);
    tick();
    total++;
    if (line_hi !== 8'h00 || vld_hi !== 1'b0) begin
      bad++;
      $display("FAIL toggle_b: line=%h valid=%b want line=00 valid=0", line_hi, vld_hi);
    end
    set_in(1'b1, 3'd4);
    tick();
    total++;
    if (line_hi !== 8'h10 || vld_hi !== 1'b1) begin
      bad++;
      $display("FAIL toggle_c: line=%h valid=%b want line=10 valid=1", line_hi, vld_hi);
    end
  endtask

  task automatic test_reset_mid();
    set_in(1'b1, 3'd6);
    tick();
    total++;
    if (line_hi !== 8'h40 || vld_hi !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre: line=%h valid=%b want line=40 valid=1", line_hi, vld_hi);
    end
    rst_n = 1'b0;
    tick();
    total++;
    if (line_hi !== 8'h00 || vld_hi !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst: line=%h valid=%b want line=00 valid=0", line_hi, vld_hi);
    end
    total++;
    if (line_cb !== 8'h40 || vld_cb !== 1'b1) begin
      bad++;
      $display("FAIL mid_rst_comb: line=%h valid=%b want line=40 valid=1", line_cb, vld_cb);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (line_hi !== 8'h40 || vld_hi !== 1'b1) begin
      bad++;
      $display("FAIL mid_post: line=%h valid=%b want line=40 valid=1", line_hi, vld_hi);
    end
  endtask

  task automatic test_polarity();
    set_in(1'b1, 3'd2);
    tick();
    total++;
    if (line_lo !== 8'hFB || vld_lo !== 1'b1) begin
      bad++;
      $display("FAIL pol_sel2: line=%h valid=%b want line=fb valid=1", line_lo, vld_lo);
    end
    set_in(1'b1, 3'd7);
    tick();
    total++;
    if (line_lo !== 8'h7F || vld_lo !== 1'b1) begin
      bad++;
      $display("FAIL pol_sel7: line=%h valid=%b want line=7f valid=1", line_lo, vld_lo);
    end
    set_in(1'b0, 3'd2);
    tick();
    total++;
    if (line_lo !== 8'hFF || vld_lo !== 1'b0) begin
      bad++;
      $display("FAIL pol_off: line=%h valid=%b want line=ff valid=0", line_lo, vld_lo);
    end
    set_in(1'b1, 3'd0);
    rst_n = 1'b0;
    tick();
    total++;
    if (line_lo !== 8'hFF || vld_lo !== 1'b0) begin
      bad++;
      $display("FAIL pol_rst: line=%h valid=%b want line=ff valid=0", line_lo, vld_lo);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (line_lo !== 8'hFE || vld_lo !== 1'b1) begin
      bad++;
      $display("FAIL pol_sel0: line=%h valid=%b want line=fe valid=1", line_lo, vld_lo);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 3'd0);
    test_reset();
    test_sweep();
    test_enable_gating();
    test_back_to_back();
    test_reset_mid();
    test_polarity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
